wb_initiator: RTL
=================

# wb_initiator

Single-transaction Wishbone classic-cycle initiator. It accepts one read or write command on a valid/ready command port and runs it as one Wishbone cycle. It waits for `ack_i`/`err_i` or a timeout, then returns the read data and status on a valid/ready response port. It lets a core or debug engine drive any Wishbone output port or peripheral in the design.

## Interface
- `DATA_WIDTH`, 32, data bus width in bits
- `ADDR_WIDTH`, 32, address bus width in bits
- `SELECT_WIDTH`, `DATA_WIDTH/8`, number of byte-select lanes
- `TIMEOUT`, 255, number of cycles `stb_o` may stay high without `ack_i`/`err_i` before abort; 0 disables the timeout

- `clk`  in  1  clock, all logic on rising edge
- `rst_n`  in  1  synchronous reset, active-low
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  block can accept a command
- `cmd_we`  in  1  1 = write, 0 = read
- `cmd_addr`  in  `ADDR_WIDTH`  target address
- `cmd_sel`  in  `SELECT_WIDTH`  byte selects
- `cmd_data`  in  `DATA_WIDTH`  write data
- `rsp_valid`  out  1  response present
- `rsp_ready`  in  1  response consumer ready
- `rsp_data`  out  `DATA_WIDTH`  `dat_i` captured at ack; 0 on error or timeout
- `rsp_err`  out  1  cycle ended by `err_i` or timeout
- `rsp_timeout`  out  1  cycle ended by timeout
- `adr_o`, `dat_o`, `we_o`, `sel_o`, `stb_o`, `cyc_o`  out  Wishbone initiator outputs
- `dat_i`, `ack_i`, `err_i`  in  Wishbone initiator inputs

## Operation
- FSM states:
  - IDLE
    - `cmd_ready`=1, decoded from the state register only.
    - On `cmd_valid` at the edge: register addr/data/we/sel onto the bus outputs, clear the timeout counter, go to BUS.
  - BUS
    - `cyc_o`=`stb_o`=1; `adr_o`/`dat_o`/`we_o`/`sel_o` held constant.
    - Counter increments each cycle.
    - On an edge with `err_i`=1: `rsp_err`=1, `rsp_timeout`=0, `rsp_data`=0, go to RESP.
    - Else if `ack_i`=1: `rsp_data`=`dat_i` (captured for writes too), `rsp_err`=0, `rsp_timeout`=0, go to RESP.
    - Else if `TIMEOUT`≠0 and the counter equals `TIMEOUT`-1: `rsp_err`=1, `rsp_timeout`=1, `rsp_data`=0, go to RESP.
  - RESP
    - `cyc_o`=`stb_o`=0, `rsp_valid`=1.
    - Response fields held stable until `rsp_valid` & `rsp_ready` at an edge, then go to IDLE.
- Priority of simultaneous events: `err_i` > `ack_i` > timeout. An ack in the final timeout cycle completes normally.
- The block never has more than one outstanding transaction. It issues no pipelined or burst cycles, and `cyc_o` equals `stb_o` at all times.
- The counter is wide enough to hold `TIMEOUT`-1 (`$clog2(TIMEOUT+1)` bits, minimum 1) and never wraps.
- Reset (`rst_n`=0 at an edge), from any state including mid-BUS:
  - State goes to IDLE.
  - `cyc_o`, `stb_o`, `we_o`, `rsp_valid`, `rsp_err`, `rsp_timeout` = 0.
  - `adr_o`, `dat_o`, `sel_o`, `rsp_data`, counter = 0.
  - Any in-flight transaction is abandoned with no response.
- While in IDLE, the bus outputs other than `cyc_o`/`stb_o` keep their last values.

## Timing
- Command handshake at edge E0 → `cyc_o`/`stb_o` high from E0 to E1 (the first BUS cycle).
- Against a zero-wait slave (`ack_i` = `stb_o` & `cyc_o`): ack sampled at E1, `rsp_valid`=1 from E1 to E2.
- Each slave wait state adds exactly one cycle.
- With `rsp_ready` tied high, throughput is 1 transaction per 3 cycles (IDLE, BUS, RESP).
- Timeout: with no ack, `stb_o` stays high for exactly `TIMEOUT` cycles, and `rsp_valid` rises on the next cycle.
- `rsp_valid` held with `rsp_ready`=0: all `rsp_*` outputs stay stable and `cmd_ready` stays 0.

## Test plan
- Zero-wait slave, write `cmd_addr`=0x10, `cmd_data`=0xDEADBEEF, `cmd_sel`=0xF → `stb_o` high exactly 1 cycle with `we_o`=1 and `dat_o`=0xDEADBEEF; `rsp_valid` the next cycle with `rsp_err`=0.
- Read from a slave with 3 wait states returning 0x12345678 → `stb_o` high 4 cycles with outputs stable throughout; `rsp_data`=0x12345678 and `rsp_err`=0.
- `TIMEOUT`=4, slave never acks → `stb_o` high 4 cycles, then `rsp_err`=1, `rsp_timeout`=1, `rsp_data`=0; the next command is accepted afterward.
- `ack_i` and `err_i` asserted together → `rsp_err`=1, `rsp_timeout`=0. Separately, ack arriving in cycle 4 with `TIMEOUT`=4 → normal completion, `rsp_err`=0.
- `rsp_ready` held 0 for 5 cycles during RESP → response fields stable, `cmd_ready`=0 and `cmd_valid` ignored; after release, back-to-back commands run 3 cycles apart.
- `rst_n`=0 for one edge during BUS → next cycle `cyc_o`=`stb_o`=`rsp_valid`=0, `cmd_ready`=1, and no response is ever produced for the aborted command.

Source files
------------

// File: rtl/wb_initiator.sv
// Single-transaction Wishbone classic-cycle initiator: one command in, one bus cycle,
// one response out, with an optional stall timeout.
module wb_initiator #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned SELECT_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_we,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [SELECT_WIDTH-1:0] cmd_sel,
    input  logic [DATA_WIDTH-1:0]   cmd_data,

    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_data,
    output logic                    rsp_err,
    output logic                    rsp_timeout,

    output logic [ADDR_WIDTH-1:0]   adr_o,
    output logic [DATA_WIDTH-1:0]   dat_o,
    output logic                    we_o,
    output logic [SELECT_WIDTH-1:0] sel_o,
    output logic                    stb_o,
    output logic                    cyc_o,
    input  logic [DATA_WIDTH-1:0]   dat_i,
    input  logic                    ack_i,
    input  logic                    err_i
);

    localparam int unsigned CNT_WIDTH = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST =
        (TIMEOUT == 0) ? '0 : CNT_WIDTH'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StBus,
        StResp
    } state_e;

    state_e               state_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 timeout_hit;

    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    // Handshake and strobe outputs are pure decodes of the state flop.
    assign cmd_ready = (state_q == StIdle);
    assign cyc_o     = (state_q == StBus);
    assign stb_o     = (state_q == StBus);
    assign rsp_valid = (state_q == StResp);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            adr_o       <= '0;
            dat_o       <= '0;
            we_o        <= 1'b0;
            sel_o       <= '0;
            rsp_data    <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        adr_o   <= cmd_addr;
                        dat_o   <= cmd_data;
                        we_o    <= cmd_we;
                        sel_o   <= cmd_sel;
                        cnt_q   <= '0;
                        state_q <= StBus;
                    end
                end
                StBus: begin
                    // Saturate so a disabled timeout never wraps the counter.
                    if (cnt_q != '1) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                    if (err_i) begin
                        rsp_data    <= '0;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b0;
                        state_q     <= StResp;
                    end else if (ack_i) begin
                        rsp_data    <= dat_i;
                        rsp_err     <= 1'b0;
                        rsp_timeout <= 1'b0;
                        state_q     <= StResp;
                    end else if (timeout_hit) begin
                        rsp_data    <= '0;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        state_q     <= StResp;
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
